// File: rtl/picorv32_mem_pkg.sv
// Shared constants for the PicoRV32 memory-side blocks: default line geometry,
// cacheable window and the instruction line buffer state encoding.
package picorv32_mem_pkg;

    localparam int          DEF_LINE_WORDS = 4;
    localparam logic [31:0] DEF_CACHE_MASK = 32'hFFFF_0000;
    localparam logic [31:0] DEF_CACHE_BASE = 32'h0000_0000;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HIT      = 3'd1;
    localparam logic [2:0] ST_PASS     = 3'd2;
    localparam logic [2:0] ST_PASS_GAP = 3'd3;
    localparam logic [2:0] ST_FILL     = 3'd4;
    localparam logic [2:0] ST_FILL_GAP = 3'd5;
    localparam logic [2:0] ST_RESP     = 3'd6;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } mem_req_t;

    function automatic logic is_cacheable(input logic [31:0] addr,
                                          input logic [31:0] mask,
                                          input logic [31:0] base);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/picorv32_iline_ram.sv
// Single-line data storage for the instruction line buffer: one synchronous
// write port fed by the fill engine, one asynchronous read port.
module picorv32_iline_ram
    import picorv32_mem_pkg::*;
#(
    parameter int WORDS = DEF_LINE_WORDS,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/picorv32_iline_buffer.sv
// One-line instruction buffer between the PicoRV32 native port and the
// downstream adapter; fetches in the cacheable window are served from the line.
module picorv32_iline_buffer
    import picorv32_mem_pkg::*;
#(
    parameter int          LINE_WORDS = DEF_LINE_WORDS,
    parameter logic [31:0] CACHE_MASK = DEF_CACHE_MASK,
    parameter logic [31:0] CACHE_BASE = DEF_CACHE_BASE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_mem_valid,
    input  logic        cpu_mem_instr,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic        cpu_mem_ready,
    output logic [31:0] cpu_mem_rdata,
    output logic        dn_mem_valid,
    output logic        dn_mem_instr,
    output logic [31:0] dn_mem_addr,
    output logic [31:0] dn_mem_wdata,
    output logic [3:0]  dn_mem_wstrb,
    input  logic        dn_mem_ready,
    input  logic [31:0] dn_mem_rdata
);

    localparam int              IDX_W  = $clog2(LINE_WORDS);
    localparam int              TAG_W  = 30 - IDX_W;
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(LINE_WORDS - 1);

    logic [2:0]       state;
    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [IDX_W-1:0] fill_k;
    logic [IDX_W-1:0] next_k;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      rd_word;
    logic [TAG_W-1:0] cpu_tag;
    logic [IDX_W-1:0] cpu_idx;
    logic             cached_fetch;
    logic             tag_hit;

    assign cpu_tag      = cpu_mem_addr[31:IDX_W+2];
    assign cpu_idx      = cpu_mem_addr[IDX_W+1:2];
    assign cached_fetch = cpu_mem_instr && (cpu_mem_wstrb == 4'b0000) &&
                          is_cacheable(cpu_mem_addr, CACHE_MASK, CACHE_BASE);
    assign tag_hit      = (cpu_tag == line_tag);
    assign next_k       = fill_k + 1'b1;
    // In IDLE the line is read with the live address so a hit answers next cycle.
    assign rd_idx       = (state == ST_IDLE) ? cpu_idx : req_idx;

    picorv32_iline_ram #(
        .WORDS (LINE_WORDS),
        .AW    (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    ((state == ST_FILL) && dn_mem_ready),
        .waddr (fill_k),
        .wdata (dn_mem_rdata),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= ST_IDLE;
            line_valid    <= 1'b0;
            line_tag      <= '0;
            fill_k        <= '0;
            req_idx       <= '0;
            cpu_mem_ready <= 1'b0;
            cpu_mem_rdata <= 32'h0;
            dn_mem_valid  <= 1'b0;
            dn_mem_instr  <= 1'b0;
            dn_mem_addr   <= 32'h0;
            dn_mem_wdata  <= 32'h0;
            dn_mem_wstrb  <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_mem_valid && !cpu_mem_ready) begin
                        req_idx <= cpu_idx;
                        if (cached_fetch && line_valid && tag_hit) begin
                            state         <= ST_HIT;
                            cpu_mem_ready <= 1'b1;
                            cpu_mem_rdata <= rd_word;
                        end else if (cached_fetch) begin
                            state        <= ST_FILL;
                            line_valid   <= 1'b0;
                            line_tag     <= cpu_tag;
                            fill_k       <= '0;
                            dn_mem_valid <= 1'b1;
                            dn_mem_instr <= 1'b1;
                            dn_mem_addr  <= {cpu_tag, {IDX_W{1'b0}}, 2'b00};
                            dn_mem_wdata <= 32'h0;
                            dn_mem_wstrb <= 4'b0000;
                        end else begin
                            state        <= ST_PASS;
                            dn_mem_valid <= 1'b1;
                            dn_mem_instr <= cpu_mem_instr;
                            dn_mem_addr  <= cpu_mem_addr;
                            dn_mem_wdata <= cpu_mem_wdata;
                            dn_mem_wstrb <= cpu_mem_wstrb;
                            // Stores into the buffered line invalidate it so patched code is refetched.
                            if ((cpu_mem_wstrb != 4'b0000) && tag_hit) begin
                                line_valid <= 1'b0;
                            end
                        end
                    end
                end
                ST_HIT, ST_RESP, ST_PASS_GAP: begin
                    cpu_mem_ready <= 1'b0;
                    state         <= ST_IDLE;
                end
                ST_PASS: begin
                    if (dn_mem_ready) begin
                        dn_mem_valid  <= 1'b0;
                        cpu_mem_ready <= 1'b1;
                        cpu_mem_rdata <= dn_mem_rdata;
                        state         <= ST_PASS_GAP;
                    end
                end
                ST_FILL: begin
                    if (dn_mem_ready) begin
                        dn_mem_valid <= 1'b0;
                        state        <= ST_FILL_GAP;
                    end
                end
                ST_FILL_GAP: begin
                    if (fill_k == LAST_K) begin
                        line_valid    <= 1'b1;
                        cpu_mem_ready <= 1'b1;
                        cpu_mem_rdata <= rd_word;
                        state         <= ST_RESP;
                    end else begin
                        fill_k       <= next_k;
                        dn_mem_addr  <= {line_tag, next_k, 2'b00};
                        dn_mem_valid <= 1'b1;
                        state        <= ST_FILL;
                    end
                end
                default: begin
                    cpu_mem_ready <= 1'b0;
                    dn_mem_valid  <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_iline_buffer.sv
// Scoreboard bench for the instruction line buffer: directed CPU requests push
// expected downstream requests and CPU read data; monitors pop and compare.
module tb_picorv32_iline_buffer;
    import picorv32_mem_pkg::*;

    logic        clk;
    logic        resetn;
    logic        cpu_mem_valid;
    logic        cpu_mem_instr;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;
    logic        dn_mem_valid;
    logic        dn_mem_instr;
    logic [31:0] dn_mem_addr;
    logic [31:0] dn_mem_wdata;
    logic [3:0]  dn_mem_wstrb;
    logic        dn_mem_ready;
    logic [31:0] dn_mem_rdata;

    int errors = 0;
    int checks = 0;
    int dnReadyCount = 0;

    logic [31:0] cpuExp [$];
    mem_req_t    dnExp [$];
    logic [31:0] memWords [logic [31:0]];

    int          respWait;
    int          respLat;
    logic [31:0] respWord;
    logic        prevValid;
    logic        gapDue;
    mem_req_t    dnHead;

    picorv32_iline_buffer dut (
        .clk           (clk),
        .resetn        (resetn),
        .cpu_mem_valid (cpu_mem_valid),
        .cpu_mem_instr (cpu_mem_instr),
        .cpu_mem_addr  (cpu_mem_addr),
        .cpu_mem_wdata (cpu_mem_wdata),
        .cpu_mem_wstrb (cpu_mem_wstrb),
        .cpu_mem_ready (cpu_mem_ready),
        .cpu_mem_rdata (cpu_mem_rdata),
        .dn_mem_valid  (dn_mem_valid),
        .dn_mem_instr  (dn_mem_instr),
        .dn_mem_addr   (dn_mem_addr),
        .dn_mem_wdata  (dn_mem_wdata),
        .dn_mem_wstrb  (dn_mem_wstrb),
        .dn_mem_ready  (dn_mem_ready),
        .dn_mem_rdata  (dn_mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memWords.exists(a)) return memWords[a];
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got event, expected none", name);
    endtask

    task automatic expectDn(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s, input logic i);
        mem_req_t r;
        r.addr  = a;
        r.wdata = w;
        r.wstrb = s;
        r.instr = i;
        dnExp.push_back(r);
    endtask

    task automatic expectFill(input logic [31:0] base);
        for (int k = 0; k < 4; k++) expectDn(base + 32'(k * 4), 32'h0, 4'b0000, 1'b1);
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, ".cpu_mem_ready"}, {31'b0, cpu_mem_ready}, 32'h0);
        checkOutput({tag, ".cpu_mem_rdata"}, cpu_mem_rdata, 32'h0);
        checkOutput({tag, ".dn_mem_valid"}, {31'b0, dn_mem_valid}, 32'h0);
        checkOutput({tag, ".dn_mem_instr"}, {31'b0, dn_mem_instr}, 32'h0);
        checkOutput({tag, ".dn_mem_addr"}, dn_mem_addr, 32'h0);
        checkOutput({tag, ".dn_mem_wdata"}, dn_mem_wdata, 32'h0);
        checkOutput({tag, ".dn_mem_wstrb"}, {28'b0, dn_mem_wstrb}, 32'h0);
    endtask

    // Issue one CPU request and wait for its ready pulse; dropAfter>0 releases valid early.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                                 input logic i, input int dropAfter, input bit expectHit);
        int  cycles;
        bit  done;
        @(negedge clk);
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = a;
        cpu_mem_wdata = w;
        cpu_mem_wstrb = s;
        cpu_mem_instr = i;
        cycles = 0;
        done   = 1'b0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (dropAfter != 0 && cycles == dropAfter) cpu_mem_valid = 1'b0;
            if (cpu_mem_ready) done = 1'b1;
        end
        cpu_mem_valid = 1'b0;
        cpu_mem_wstrb = 4'b0000;
        cpu_mem_wdata = 32'h0;
        if (!done) failNow("cpuReadyTimeout");
        if (expectHit) checkOutput("hitLatency", 32'(cycles), 32'd1);
    endtask

    // Downstream responder with a rotating 0..2 cycle latency.
    initial begin
        dn_mem_ready = 1'b0;
        dn_mem_rdata = 32'h0;
        respWait = 0;
        respLat  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dn_mem_ready) begin
                dn_mem_ready = 1'b0;
            end else if (dn_mem_valid) begin
                if (respWait >= respLat) begin
                    if (dn_mem_wstrb != 4'b0000) begin
                        respWord = memRead(dn_mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (dn_mem_wstrb[b]) respWord[b*8 +: 8] = dn_mem_wdata[b*8 +: 8];
                        memWords[dn_mem_addr] = respWord;
                        dn_mem_rdata = 32'h0;
                    end else begin
                        dn_mem_rdata = memRead(dn_mem_addr);
                    end
                    dn_mem_ready = 1'b1;
                    dnReadyCount++;
                    respWait = 0;
                    respLat  = (respLat + 1) % 3;
                end else begin
                    respWait++;
                end
            end
        end
    end

    // Downstream monitor: request contents and the mandatory idle gap.
    initial begin
        prevValid = 1'b0;
        gapDue    = 1'b0;
        forever begin
            @(negedge clk);
            if (gapDue) begin
                checkOutput("dnGap", {31'b0, dn_mem_valid}, 32'h0);
                gapDue = 1'b0;
            end
            if (dn_mem_valid && !prevValid) begin
                if (dnExp.size() == 0) begin
                    failNow("unexpectedDnRequest");
                    $display("[TB]   stray downstream address %08h", dn_mem_addr);
                end else begin
                    dnHead = dnExp.pop_front();
                    checkOutput("dnAddr", dn_mem_addr, dnHead.addr);
                    checkOutput("dnWdata", dn_mem_wdata, dnHead.wdata);
                    checkOutput("dnWstrb", {28'b0, dn_mem_wstrb}, {28'b0, dnHead.wstrb});
                    checkOutput("dnInstr", {31'b0, dn_mem_instr}, {31'b0, dnHead.instr});
                end
            end
            if (dn_mem_valid && dn_mem_ready) gapDue = 1'b1;
            prevValid = dn_mem_valid;
        end
    end

    // CPU monitor: every ready pulse consumes one expected read word.
    initial begin
        forever begin
            @(negedge clk);
            if (cpu_mem_ready) begin
                if (cpuExp.size() == 0) failNow("unexpectedCpuReady");
                else checkOutput("cpuRdata", cpu_mem_rdata, cpuExp.pop_front());
            end
        end
    end

    initial begin
        int target;
        int cnt;
        resetn        = 1'b0;
        cpu_mem_valid = 1'b0;
        cpu_mem_instr = 1'b0;
        cpu_mem_addr  = 32'h0;
        cpu_mem_wdata = 32'h0;
        cpu_mem_wstrb = 4'b0000;
        repeat (3) @(negedge clk);
        checkZeroOutputs("reset");
        resetn = 1'b1;

        // Cold fetch fills the whole line starting at word 0.
        expectFill(32'h0000_0100);
        cpuExp.push_back(32'hC0DE_0104);
        applyStimulus(32'h0000_0104, 32'h0, 4'b0000, 1'b1, 0, 1'b0);

        cpuExp.push_back(32'hC0DE_0108);
        applyStimulus(32'h0000_0108, 32'h0, 4'b0000, 1'b1, 0, 1'b1);
        cpuExp.push_back(32'hC0DE_010C);
        applyStimulus(32'h0000_010C, 32'h0, 4'b0000, 1'b1, 0, 1'b1);
        cpuExp.push_back(32'hC0DE_0100);
        applyStimulus(32'h0000_0100, 32'h0, 4'b0000, 1'b1, 0, 1'b1);

        // Data read bypasses a matching valid line.
        expectDn(32'h0000_0104, 32'h0, 4'b0000, 1'b0);
        cpuExp.push_back(32'hC0DE_0104);
        applyStimulus(32'h0000_0104, 32'h0, 4'b0000, 1'b0, 0, 1'b0);
        cpuExp.push_back(32'hC0DE_0104);
        applyStimulus(32'h0000_0104, 32'h0, 4'b0000, 1'b1, 0, 1'b1);

        // Non-cacheable fetch passes through and leaves the line alone.
        expectDn(32'h8000_0000, 32'h0, 4'b0000, 1'b1);
        cpuExp.push_back(32'hC0DE_0000);
        applyStimulus(32'h8000_0000, 32'h0, 4'b0000, 1'b1, 0, 1'b0);
        cpuExp.push_back(32'hC0DE_010C);
        applyStimulus(32'h0000_010C, 32'h0, 4'b0000, 1'b1, 0, 1'b1);

        // Store into the line invalidates it; the next fetch sees patched memory.
        expectDn(32'h0000_0100, 32'h0000_00EE, 4'b0001, 1'b0);
        cpuExp.push_back(32'h0000_0000);
        applyStimulus(32'h0000_0100, 32'h0000_00EE, 4'b0001, 1'b0, 0, 1'b0);
        expectFill(32'h0000_0100);
        cpuExp.push_back(32'hC0DE_01EE);
        applyStimulus(32'h0000_0100, 32'h0, 4'b0000, 1'b1, 0, 1'b0);

        // Valid dropped mid-transfer still completes with one ready pulse.
        expectDn(32'h0000_3000, 32'h0, 4'b0000, 1'b0);
        cpuExp.push_back(32'hC0DE_3000);
        applyStimulus(32'h0000_3000, 32'h0, 4'b0000, 1'b0, 1, 1'b0);

        // Reset after the second fill word: outputs clear at once, line stays invalid.
        expectDn(32'h0000_0200, 32'h0, 4'b0000, 1'b1);
        expectDn(32'h0000_0204, 32'h0, 4'b0000, 1'b1);
        @(negedge clk);
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h0000_0204;
        cpu_mem_instr = 1'b1;
        target = dnReadyCount + 2;
        cnt    = 0;
        while (dnReadyCount < target && cnt < 200) begin
            @(posedge clk);
            cnt++;
        end
        if (dnReadyCount < target) failNow("fillProgressTimeout");
        #3;
        resetn        = 1'b0;
        cpu_mem_valid = 1'b0;
        #1;
        checkZeroOutputs("midFillReset");
        @(negedge clk);
        resetn = 1'b1;

        expectFill(32'h0000_0200);
        cpuExp.push_back(32'hC0DE_0204);
        applyStimulus(32'h0000_0204, 32'h0, 4'b0000, 1'b1, 0, 1'b0);
        cpuExp.push_back(32'hC0DE_0200);
        applyStimulus(32'h0000_0200, 32'h0, 4'b0000, 1'b1, 0, 1'b1);

        repeat (6) @(negedge clk);
        checkOutput("cpuExpDrained", 32'(cpuExp.size()), 32'd0);
        checkOutput("dnExpDrained", 32'(dnExp.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/picorv32_iline_buffer.md
PICORV32_ILINE_BUFFER -- requirements
Module: picorv32_iline_buffer

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, meaning words per line (power of two, 2..16).
REQ-002 SHALL have parameter CACHE_MASK, default 32'hFFFF_0000, meaning address bits compared against CACHE_BASE.
REQ-003 SHALL have parameter CACHE_BASE, default 32'h0000_0000, meaning a fetch is cacheable iff (addr & CACHE_MASK) == CACHE_BASE.
REQ-004 clk  in  1  clock; resetn  in  1  asynchronous, active-low reset.
REQ-005 cpu_mem_valid in 1, cpu_mem_instr in 1, cpu_mem_addr in 32, cpu_mem_wdata in 32, cpu_mem_wstrb in 4: PicoRV32 native request.
REQ-006 cpu_mem_ready  out  1  one-cycle completion pulse; cpu_mem_rdata  out  32  read data, valid while cpu_mem_ready=1.
REQ-007 dn_mem_valid out 1, dn_mem_instr out 1, dn_mem_addr out 32, dn_mem_wdata out 32, dn_mem_wstrb out 4: native request to downstream AHB adapter.
REQ-008 dn_mem_ready  in  1  downstream completion pulse; dn_mem_rdata  in  32  downstream read data, sampled when dn_mem_ready=1.

Function
REQ-009 SHALL hold one line: tag (addr[31:log2(LINE_WORDS)+2]), valid bit, LINE_WORDS x 32-bit data.
REQ-010 States: IDLE, HIT, PASS, PASS_GAP, FILL, FILL_GAP, RESP.
REQ-011 IDLE, cpu_mem_valid=1, cpu_mem_ready=0, wstrb=0, instr=1, cacheable, valid, tag match -> HIT; HIT drives cpu_mem_ready=1 with line word addr[log2(LINE_WORDS)+1:2]; hit latency 1 cycle after request sampled.
REQ-012 IDLE, instruction fetch cacheable but miss -> FILL with k=0, valid cleared; fill address {tag, k, 2'b00}, dn_mem_wstrb=0, dn_mem_instr=1.
REQ-013 FILL: dn_mem_valid=1 until dn_mem_ready=1; on ready store dn_mem_rdata into word k, go FILL_GAP with dn_mem_valid=0 for exactly one cycle; k<LINE_WORDS-1 -> k+1, FILL; else set valid, tag -> RESP.
REQ-014 RESP: cpu_mem_ready=1 one cycle with requested word, then IDLE.
REQ-015 IDLE, any other request (data read, write, non-cacheable fetch) -> PASS: forward addr/wdata/wstrb/instr unmodified, dn_mem_valid=1 until dn_mem_ready.
REQ-016 PASS on dn_mem_ready: registered cpu_mem_ready=1 next cycle with latched dn_mem_rdata, dn_mem_valid=0, -> PASS_GAP; PASS_GAP -> IDLE.
REQ-017 dn_mem_valid SHALL be low at least one cycle between any two downstream requests.
REQ-018 Write (wstrb!=0) whose tag matches the held line SHALL clear valid on entering PASS (self-modifying code coherence).
REQ-019 Data reads SHALL always bypass the line even on tag match.
REQ-020 Request sampled only in IDLE; cpu_mem_valid deasserting mid-transaction SHALL NOT abort a started downstream transfer; cpu_mem_ready still pulses.
REQ-021 dn_mem_ready in IDLE, HIT, RESP, *_GAP SHALL be ignored.
REQ-022 cpu_mem_ready SHALL be exactly one cycle per accepted request; IDLE not re-entered until cpu_mem_ready has been high, so a held cpu_mem_valid is not re-accepted in the same cycle.

Reset
REQ-023 resetn=0 asynchronously forces IDLE, valid=0, k=0, cpu_mem_ready=0, cpu_mem_rdata=0, dn_mem_valid=0, dn_mem_wstrb=0, dn_mem_addr=0, dn_mem_wdata=0, dn_mem_instr=0.
REQ-024 Reset mid-FILL SHALL leave line invalid; partially filled words never served.
REQ-025 Line data array need not be reset.

Structure
REQ-026 State encoding and default LINE_WORDS/CACHE_* constants SHALL live in shared package picorv32_mem_pkg.
REQ-027 Line storage (LINE_WORDS x 32, 1 write port, 1 read port) SHALL be sub-module picorv32_iline_ram; FSM, tag, valid stay in top.

Verification
REQ-028 Cold fetch 0x0000_0104 -> downstream reads 0x100,0x104,0x108,0x10C, each separated by dn_mem_valid=0 cycle; cpu_mem_ready once with word at 0x104.
REQ-029 Following fetch 0x0000_0108 -> no downstream activity, cpu_mem_ready 1 cycle after request, data = filled word.
REQ-030 Write 0x0000_0100 wstrb=4'b0001 after fill -> passthrough write, valid cleared; next fetch 0x100 refills whole line.
REQ-031 Data read 0x0000_0104 with valid line -> passthrough, cpu_mem_rdata = dn_mem_rdata, line untouched.
REQ-032 Fetch 0x8000_0000 (non-cacheable, default mask) -> single passthrough read, dn_mem_instr=1, valid unchanged.
REQ-033 resetn low after second fill word -> all outputs zero immediately; next fetch of same line refills from word 0.
